cfs_apb_slave: RTL and testbench

CFS_APB_SLAVE -- requirements
Module: cfs_apb_slave

---
 rtl/cfs_apb_slave_pkg.sv | 29 ++
 rtl/cfs_apb_slave_regs.sv | 76 +++++++
 rtl/cfs_apb_slave.sv | 119 +++++++++++
 tb/tb_cfs_apb_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfs_apb_slave_pkg.sv
// Shared constants for the CFS APB register slave: state encoding, register map and ID.
// Optional wait-state support is enabled with CFS_APB_SLAVE_WAIT_STATES_EN.
package cfs_apb_slave_pkg;

  localparam int NUM_REGS = 8;
  localparam int WAIT_W   = 4;

  localparam logic [31:0] ID_VALUE = 32'hCF5A_0001;

  localparam logic [4:0] OFF_ID            = 5'h00;
  localparam logic [4:0] OFF_CTRL          = 5'h04;
  localparam logic [4:0] OFF_SCRATCH_FIRST = 5'h08;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_READY = 2'd2;

  typedef struct packed {
    logic       err;
    logic [2:0] idx;
  } decode_t;

  function automatic logic [2:0] reg_index(input logic [4:0] offset);
    return offset[4:2];
  endfunction

endpackage

// File: rtl/cfs_apb_slave_regs.sv
// Register file, address decode and read mux for the CFS APB slave.
// CTRL storage only exists when CFS_APB_SLAVE_WAIT_STATES_EN is defined.
module cfs_apb_slave_regs
  import cfs_apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  commit,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
  ,
  output logic [WAIT_W-1:0]     wait_cfg
`endif
);

  localparam int         NUM_SCRATCH = NUM_REGS - 2;
  localparam logic [2:0] IDX_ID      = reg_index(OFF_ID);
  localparam logic [2:0] IDX_CTRL    = reg_index(OFF_CTRL);
  localparam logic [2:0] IDX_SCRATCH = reg_index(OFF_SCRATCH_FIRST);

  decode_t               dec;
  logic [2:0]            slot;
  logic [DATA_WIDTH-1:0] scratch [NUM_SCRATCH];

  // Misaligned, out-of-map and ID writes are all rejected with the same error.
  always_comb begin
    dec.idx = paddr[4:2];
    dec.err = (paddr[1:0] != 2'b00)
           || (paddr[ADDR_WIDTH-1:5] != '0)
           || (pwrite && (paddr[4:2] == IDX_ID));
  end

  assign slot = dec.idx - IDX_SCRATCH;
  assign err  = dec.err;

  always_comb begin
    rdata = '0;
    case (dec.idx)
      IDX_ID:   rdata = ID_VALUE;
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
      IDX_CTRL: rdata = {{(DATA_WIDTH-WAIT_W){1'b0}}, wait_cfg};
`else
      IDX_CTRL: rdata = '0;
`endif
      default:  rdata = scratch[slot];
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch[i] <= '0;
      end
    end else if (commit && (dec.idx >= IDX_SCRATCH)) begin
      scratch[slot] <= pwdata;
    end
  end

`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cfg <= '0;
    end else if (commit && (dec.idx == IDX_CTRL)) begin
      wait_cfg <= pwdata[WAIT_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/cfs_apb_slave.sv
// CFS APB slave top: transfer FSM, wait counter and registered APB outputs.
// Programmable wait states (CTRL.WAIT) exist only with CFS_APB_SLAVE_WAIT_STATES_EN.
module cfs_apb_slave
  import cfs_apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  state_t                state;
  state_t                state_next;
  logic                  ready_next;
  logic                  commit;
  logic                  reg_err;
  logic [DATA_WIDTH-1:0] reg_rdata;

`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
  logic [WAIT_W-1:0] wait_cfg;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
`endif

  // Only the completing access cycle of a clean write may touch storage.
  assign commit = (state == ST_READY) && psel && penable && pready && pwrite && !pslverr;

  cfs_apb_slave_regs #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regs (
    .pclk     (pclk),
    .preset_n (preset_n),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .commit   (commit),
    .rdata    (reg_rdata),
    .err      (reg_err)
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
    ,
    .wait_cfg (wait_cfg)
`endif
  );

  always_comb begin
    state_next = state;
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
    wait_cnt_next = wait_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (psel && !penable) begin
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
          // The wait count is sampled here so later CTRL writes cannot stretch this transfer.
          if (wait_cfg != '0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = wait_cfg;
          end else begin
            state_next = ST_READY;
          end
`else
          state_next = ST_READY;
`endif
        end
      end
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
      ST_WAIT: begin
        wait_cnt_next = wait_cnt - WAIT_W'(1);
        if (!psel) begin
          state_next    = ST_IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_W'(1)) begin
          state_next = ST_READY;
        end
      end
`endif
      ST_READY: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign ready_next = (state_next == ST_READY);

  // Response is captured on entry to READY so all APB outputs come straight from flops.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= ST_IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_next;
      pready  <= ready_next;
      pslverr <= ready_next && reg_err;
      prdata  <= (ready_next && !pwrite && !reg_err) ? reg_rdata : '0;
    end
  end

`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_cfs_apb_slave.sv
// Self-checking bench for cfs_apb_slave; adapts its model to CFS_APB_SLAVE_WAIT_STATES_EN.
// A transaction-level register model predicts every response cycle; directed cases pin literals.
module tb_cfs_apb_slave;

  localparam logic [31:0] ID_VALUE = 32'hCF5A_0001;

  logic        pclk     = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel     = 1'b0;
  logic        penable  = 1'b0;
  logic        pwrite   = 1'b0;
  logic [15:0] paddr    = '0;
  logic [31:0] pwdata   = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  logic        exp_valid   = 1'b0;
  logic        exp_pready  = 1'b0;
  logic        exp_pslverr = 1'b0;
  logic [31:0] exp_prdata  = '0;

  logic [31:0] model_mem [8];
  logic [3:0]  model_ctrl;

  int          cap_first_ready;
  logic [31:0] cap_rdata;
  logic        cap_err;

  always #5 pclk = ~pclk;

  cfs_apb_slave #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (exp_valid) begin
      checkOutput("pready",  32'(pready),  32'(exp_pready));
      checkOutput("pslverr", 32'(pslverr), 32'(exp_pslverr));
      checkOutput("prdata",  prdata,       exp_prdata);
    end
  end

  function automatic int effective_wait();
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
    return int'(model_ctrl);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    if (addr == 16'h0000) return ID_VALUE;
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
    if (addr == 16'h0004) return {28'd0, model_ctrl};
`else
    if (addr == 16'h0004) return 32'd0;
`endif
    if (addr < 16'h0020) return model_mem[addr[4:2]];
    return 32'd0;
  endfunction

  task automatic model_reset();
    model_ctrl = 4'd0;
    for (int i = 0; i < 8; i++) model_mem[i] = 32'd0;
  endtask

  task automatic set_exp(input logic rdy, input logic serr, input logic [31:0] data);
    exp_pready  = rdy;
    exp_pslverr = serr;
    exp_prdata  = data;
  endtask

  // One APB transfer; drop_after >= 0 releases psel after that many access cycles.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                               input int drop_after);
    int          w;
    logic        err;
    logic [31:0] rd;
    logic        aborted;
    err     = (addr[1:0] != 2'b00) || (addr >= 16'h0020) || (wr && addr == 16'h0000);
    w       = effective_wait();
    rd      = (wr || err) ? 32'd0 : model_read(addr);
    aborted = 1'b0;
    cap_first_ready = 0;
    cap_rdata       = '0;
    cap_err         = 1'b0;
    @(posedge pclk); #1;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wr ? data : $urandom;
    set_exp(1'b0, 1'b0, 32'd0);
    exp_valid = 1'b1;
    for (int c = 1; c <= w + 1; c++) begin
      @(posedge pclk); #1;
      if (drop_after >= 0 && c > drop_after) begin
        psel    = 1'b0;
        penable = 1'b0;
        aborted = 1'b1;
        set_exp(1'b0, 1'b0, 32'd0);
      end else begin
        penable = 1'b1;
        if (c == w + 1) set_exp(1'b1, err, rd);
        else            set_exp(1'b0, 1'b0, 32'd0);
      end
      @(negedge pclk);
      if (pready === 1'b1 && cap_first_ready == 0) begin
        cap_first_ready = c;
        cap_rdata       = prdata;
        cap_err         = pslverr;
      end
      if (aborted) break;
    end
    if (!aborted && wr && !err) begin
      if (addr == 16'h0004) begin
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
        model_ctrl = data[3:0];
`endif
      end else begin
        model_mem[addr[4:2]] = data;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      psel    = 1'b0;
      penable = 1'b0;
      set_exp(1'b0, 1'b0, 32'd0);
    end
  endtask

  initial begin
    int          w;
    int          drop;
    int          r;
    logic        wr;
    logic [15:0] addr;

    model_reset();

    #12;
    checkOutput("reset_pready",  32'(pready),  32'd0);
    checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
    checkOutput("reset_prdata",  prdata,       32'd0);
    #10;
    preset_n = 1'b1;
    @(negedge pclk);
    checkOutput("post_reset_pready", 32'(pready), 32'd0);
    checkOutput("post_reset_prdata", prdata,      32'd0);

    // Basic scratch write/read with zero wait states
    applyStimulus(1'b1, 16'h0008, 32'hDEAD_BEEF, -1);
    checkOutput("wr08_ready_cycle", 32'(cap_first_ready), 32'd1);
    checkOutput("wr08_pslverr",     32'(cap_err),         32'd0);
    applyStimulus(1'b0, 16'h0008, 32'd0, -1);
    checkOutput("rd08_ready_cycle", 32'(cap_first_ready), 32'd1);
    checkOutput("rd08_prdata",      cap_rdata,            32'hDEAD_BEEF);
    checkOutput("rd08_pslverr",     32'(cap_err),         32'd0);

    // CTRL.WAIT = 3 stretches the following transfer by three cycles
    applyStimulus(1'b1, 16'h0004, 32'h0000_0003, -1);
    checkOutput("wrctrl_ready_cycle", 32'(cap_first_ready), 32'd1);
    checkOutput("wrctrl_pslverr",     32'(cap_err),         32'd0);
    applyStimulus(1'b0, 16'h0000, 32'd0, -1);
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
    checkOutput("rdid_ready_cycle", 32'(cap_first_ready), 32'd4);
`else
    checkOutput("rdid_ready_cycle", 32'(cap_first_ready), 32'd1);
`endif
    checkOutput("rdid_prdata", cap_rdata, 32'hCF5A_0001);
    applyStimulus(1'b0, 16'h0004, 32'd0, -1);
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
    checkOutput("rdctrl_prdata", cap_rdata, 32'h0000_0003);
`else
    checkOutput("rdctrl_prdata", cap_rdata, 32'h0000_0000);
`endif
    applyStimulus(1'b1, 16'h0004, 32'h0000_0000, -1);

    // Error responses: ID write, misaligned read, out-of-map read
    applyStimulus(1'b1, 16'h0000, 32'h1111_1111, -1);
    checkOutput("wrid_pslverr",     32'(cap_err),         32'd1);
    checkOutput("wrid_ready_cycle", 32'(cap_first_ready), 32'd1);
    applyStimulus(1'b0, 16'h0022, 32'd0, -1);
    checkOutput("rd22_pslverr", 32'(cap_err), 32'd1);
    checkOutput("rd22_prdata",  cap_rdata,    32'd0);
    applyStimulus(1'b0, 16'h0040, 32'd0, -1);
    checkOutput("rd40_pslverr", 32'(cap_err), 32'd1);
    checkOutput("rd40_prdata",  cap_rdata,    32'd0);
    applyStimulus(1'b0, 16'h0000, 32'd0, -1);
    checkOutput("rdid_after_err", cap_rdata,    32'hCF5A_0001);
    checkOutput("rdid_no_err",    32'(cap_err), 32'd0);

    // Back-to-back write then read with no idle cycle between them
    applyStimulus(1'b1, 16'h001C, 32'h5A5A_1C1C, -1);
    applyStimulus(1'b0, 16'h001C, 32'd0, -1);
    checkOutput("b2b_rd1c_prdata", cap_rdata, 32'h5A5A_1C1C);
    idleCycles(2);

    // psel dropped during wait states must not commit the write
    applyStimulus(1'b1, 16'h000C, 32'h0C0C_0C0C, -1);
`ifdef CFS_APB_SLAVE_WAIT_STATES_EN
    applyStimulus(1'b1, 16'h0004, 32'h0000_0005, -1);
    applyStimulus(1'b1, 16'h000C, 32'hBAD0_BAD0, 2);
    checkOutput("drop_no_ready", 32'(cap_first_ready), 32'd0);
    idleCycles(1);
`endif
    applyStimulus(1'b0, 16'h000C, 32'd0, -1);
    checkOutput("rd0c_old_value", cap_rdata, 32'h0C0C_0C0C);

    // Asynchronous reset in the middle of a write transfer
    applyStimulus(1'b1, 16'h0010, 32'h1010_1010, -1);
    @(posedge pclk); #1;
    exp_valid = 1'b0;
    psel      = 1'b1;
    penable   = 1'b0;
    pwrite    = 1'b1;
    paddr     = 16'h0010;
    pwdata    = 32'hFFFF_0000;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2;
    preset_n = 1'b0;
    #1;
    checkOutput("midrst_pready",  32'(pready),  32'd0);
    checkOutput("midrst_pslverr", 32'(pslverr), 32'd0);
    checkOutput("midrst_prdata",  prdata,       32'd0);
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    model_reset();
    @(negedge pclk); #1;
    preset_n = 1'b1;
    set_exp(1'b0, 1'b0, 32'd0);
    exp_valid = 1'b1;
    applyStimulus(1'b0, 16'h0010, 32'd0, -1);
    checkOutput("rd10_after_rst", cap_rdata, 32'd0);
    checkOutput("rd10_ready_cycle", 32'(cap_first_ready), 32'd1);
    applyStimulus(1'b0, 16'h0004, 32'd0, -1);
    checkOutput("rdctrl_after_rst", cap_rdata, 32'd0);

    // Randomized traffic against the register model
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       addr = 16'($urandom_range(0, 7) * 4);
      else if (r == 7) addr = 16'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else             addr = 16'($urandom_range(32, 65535));
      wr   = 1'($urandom_range(0, 1));
      w    = effective_wait();
      drop = -1;
      if (w >= 1 && $urandom_range(0, 3) == 0) drop = int'($urandom_range(0, w - 1));
      applyStimulus(wr, addr, $urandom, drop);
      if (drop >= 0 || $urandom_range(0, 4) == 0) idleCycles(int'($urandom_range(1, 2)));
    end

    idleCycles(2);
    exp_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
